macc_scheduler: RTL and testbench

MACC_SCHEDULER -- requirements
Module: macc_scheduler

---
 rtl/macc_scheduler_if.sv | 47 ++++
 rtl/macc_scheduler.sv | 162 ++++++++++++++++
 tb/tb_macc_scheduler.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/macc_scheduler_if.sv
// macc_scheduler_if: bundles the instruction stream and all FIFO handshakes of macc_scheduler.
//   instr_valid/instr/instr_ready       instruction fetch handshake
//   input_empty/input_dout/input_de     show-ahead input FIFO pop side
//   work_full/work_en/work_din          work FIFO push side
//   macc_full/macc_empty/macc_dout/
//   macc_en/macc_de/macc_din            MAC-result FIFO push and pop sides
//   output_full/output_en/output_din    output FIFO push side
//   busy/stall_cnt                      status
// master: the scheduler. slave: the surrounding FIFOs, fetch unit and status consumer.
interface macc_scheduler_if #(
  parameter int unsigned STALL_W = 16
);
  logic               instr_valid;
  logic [31:0]        instr;
  logic               instr_ready;
  logic               input_empty;
  logic [31:0]        input_dout;
  logic               input_de;
  logic               work_full;
  logic               work_en;
  logic [31:0]        work_din;
  logic               macc_full;
  logic               macc_empty;
  logic [31:0]        macc_dout;
  logic               macc_en;
  logic               macc_de;
  logic [31:0]        macc_din;
  logic               output_full;
  logic               output_en;
  logic [31:0]        output_din;
  logic               busy;
  logic [STALL_W-1:0] stall_cnt;

  modport master (
    input  instr_valid, instr, input_empty, input_dout, work_full,
           macc_full, macc_empty, macc_dout, output_full,
    output instr_ready, input_de, work_en, work_din, macc_en, macc_de,
           macc_din, output_en, output_din, busy, stall_cnt
  );

  modport slave (
    output instr_valid, instr, input_empty, input_dout, work_full,
           macc_full, macc_empty, macc_dout, output_full,
    input  instr_ready, input_de, work_en, work_din, macc_en, macc_de,
           macc_din, output_en, output_din, busy, stall_cnt
  );
endinterface

// File: rtl/macc_scheduler.sv
// macc_scheduler: executes a 4-op instruction stream (I load, M multiply-accumulate,
// A accumulate-push, F flush/reduce) against show-ahead FIFOs.
//   clk    sole clock, rising edge
//   reset  asynchronous active-low reset
//   bus    macc_scheduler_if.master: instruction, FIFO handshakes, busy, stall_cnt
// All strobes are combinational from state and inputs; registers update on the same edge.
module macc_scheduler #(
  parameter int unsigned STALL_W = 16
) (
  input logic              clk,
  input logic              reset,
  macc_scheduler_if.master bus
);

  typedef enum logic [1:0] {StRun, StFlush, StEmit} state_e;

  localparam logic [1:0] OpI = 2'b00;
  localparam logic [1:0] OpM = 2'b01;
  localparam logic [1:0] OpA = 2'b10;
  localparam logic [1:0] OpF = 2'b11;

  state_e             state_q, state_d;
  logic [15:0]        x_q, x_d;
  logic [15:0]        xl_q, xl_d;
  logic [15:0]        acc_q, acc_d;
  logic [15:0]        sum_q, sum_d;
  logic [STALL_W-1:0] stall_q, stall_d;

  logic [1:0]  op;
  logic [15:0] imm;
  logic [15:0] in_val, in_life;
  logic [15:0] mac;
  logic        stall;

  assign op      = bus.instr[31:30];
  assign imm     = bus.instr[15:0];
  assign in_val  = bus.input_dout[31:16];
  assign in_life = bus.input_dout[15:0];
  // Low 16 bits of a product are the same for signed and unsigned operands.
  assign mac     = x_q * imm + acc_q;

  always_comb begin
    state_d         = state_q;
    x_d             = x_q;
    xl_d            = xl_q;
    acc_d           = acc_q;
    sum_d           = sum_q;
    stall           = 1'b0;
    bus.instr_ready = 1'b0;
    bus.input_de    = 1'b0;
    bus.work_en     = 1'b0;
    bus.work_din    = '0;
    bus.macc_en     = 1'b0;
    bus.macc_de     = 1'b0;
    bus.macc_din    = '0;
    bus.output_en   = 1'b0;
    bus.output_din  = '0;

    unique case (state_q)
      StRun: begin
        if (bus.instr_valid) begin
          unique case (op)
            OpI: begin
              if (!bus.input_empty && (in_life <= 16'd1 || !bus.work_full)) begin
                bus.input_de    = 1'b1;
                bus.instr_ready = 1'b1;
                x_d             = in_val;
                xl_d            = in_life;
                // Words with lifetime left are recycled to the work FIFO.
                if (in_life > 16'd1) begin
                  bus.work_en  = 1'b1;
                  bus.work_din = {in_val, in_life - 16'd1};
                end
              end else begin
                stall = 1'b1;
              end
            end
            OpM: begin
              acc_d           = mac;
              bus.instr_ready = 1'b1;
            end
            OpA: begin
              if (imm == 16'd0) begin
                acc_d           = '0;
                bus.instr_ready = 1'b1;
              end else if (!bus.macc_full) begin
                bus.macc_en     = 1'b1;
                bus.macc_din    = {acc_q, imm};
                acc_d           = '0;
                bus.instr_ready = 1'b1;
              end else begin
                stall = 1'b1;
              end
            end
            OpF: begin
              // F is consumed only when EMIT completes.
              sum_d   = '0;
              state_d = StFlush;
            end
            default: ;
          endcase
        end
      end
      StFlush: begin
        if (!bus.macc_empty) begin
          bus.macc_de = 1'b1;
          sum_d       = sum_q + bus.macc_dout[31:16];
        end else begin
          state_d = StEmit;
        end
      end
      StEmit: begin
        if (!bus.output_full) begin
          bus.output_en   = 1'b1;
          bus.output_din  = {sum_q, 16'd1};
          bus.instr_ready = 1'b1;
          state_d         = StRun;
        end else begin
          stall = 1'b1;
        end
      end
      default: state_d = StRun;
    endcase

    stall_d = (stall && stall_q != '1) ? stall_q + STALL_W'(1) : stall_q;

    // Inputs may be live while reset is held; keep every output quiet.
    if (!reset) begin
      bus.instr_ready = 1'b0;
      bus.input_de    = 1'b0;
      bus.work_en     = 1'b0;
      bus.work_din    = '0;
      bus.macc_en     = 1'b0;
      bus.macc_de     = 1'b0;
      bus.macc_din    = '0;
      bus.output_en   = 1'b0;
      bus.output_din  = '0;
    end
  end

  assign bus.busy      = reset && (state_q != StRun);
  assign bus.stall_cnt = stall_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StRun;
      x_q     <= '0;
      xl_q    <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      xl_q    <= xl_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      stall_q <= stall_d;
    end
  end

endmodule

// File: tb/tb_macc_scheduler.sv
module tb_macc_scheduler;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  int   exp_stall;

  logic [31:0] work_q[$];
  logic [31:0] macc_q[$];
  logic [31:0] out_q[$];

  macc_scheduler_if #(.STALL_W(16)) bus ();

  macc_scheduler #(.STALL_W(16)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [1:0] op, input logic [15:0] imm);
    return {op, 14'd0, imm};
  endfunction

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // Scoreboard: every push the DUT makes must match the oldest expected word.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (bus.work_en === 1'b1) begin
        chk("work_no_full", {31'd0, bus.work_full}, 32'd0);
        if (work_q.size() == 0) chk("work_unexpected", 32'd1, 32'd0);
        else chk("work_din", bus.work_din, work_q.pop_front());
      end
      if (bus.macc_en === 1'b1) begin
        chk("macc_no_full", {31'd0, bus.macc_full}, 32'd0);
        if (macc_q.size() == 0) chk("macc_unexpected", 32'd1, 32'd0);
        else chk("macc_din", bus.macc_din, macc_q.pop_front());
      end
      if (bus.output_en === 1'b1) begin
        chk("out_no_full", {31'd0, bus.output_full}, 32'd0);
        if (out_q.size() == 0) chk("out_unexpected", 32'd1, 32'd0);
        else chk("output_din", bus.output_din, out_q.pop_front());
      end
      if (bus.macc_de === 1'b1) chk("macc_de_no_empty", {31'd0, bus.macc_empty}, 32'd0);
      if (bus.input_de === 1'b1) chk("input_de_no_empty", {31'd0, bus.input_empty}, 32'd0);
    end
  end

  initial begin
    checks      = 0;
    failures    = 0;
    exp_stall   = 0;
    reset       = 1'b0;
    bus.instr_valid = 1'b1;
    bus.instr       = mk(2'b00, 16'd0);
    bus.input_empty = 1'b0;
    bus.input_dout  = 32'h0007_0003;
    bus.work_full   = 1'b0;
    bus.macc_full   = 1'b0;
    bus.macc_empty  = 1'b1;
    bus.macc_dout   = 32'd0;
    bus.output_full = 1'b0;

    // Reset holds all outputs low even with a ready I instruction presented.
    sample();
    chk("rst_instr_ready", {31'd0, bus.instr_ready}, 32'd0);
    chk("rst_input_de", {31'd0, bus.input_de}, 32'd0);
    chk("rst_work_en", {31'd0, bus.work_en}, 32'd0);
    chk("rst_work_din", bus.work_din, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_stall", {16'd0, bus.stall_cnt}, 32'd0);
    next();
    reset = 1'b1;

    // I with lifetime 1: load X=-2, no work push.
    bus.input_dout = 32'hfffe_0001;
    sample();
    chk("i1_input_de", {31'd0, bus.input_de}, 32'd1);
    chk("i1_ready", {31'd0, bus.instr_ready}, 32'd1);
    chk("i1_work_en", {31'd0, bus.work_en}, 32'd0);
    next();
    chk("i1_x", {16'd0, dut.x_q}, 32'h0000_fffe);

    // M 5: ACC = -10.
    bus.input_empty = 1'b1;
    bus.instr       = mk(2'b01, 16'd5);
    sample();
    chk("m5_ready", {31'd0, bus.instr_ready}, 32'd1);
    next();
    chk("m5_acc", {16'd0, dut.acc_q}, 32'h0000_fff6);

    // A 1: push {ACC, 1}, ACC cleared.
    bus.instr = mk(2'b10, 16'd1);
    macc_q.push_back(32'hfff6_0001);
    sample();
    chk("a1_macc_en", {31'd0, bus.macc_en}, 32'd1);
    next();
    chk("a1_acc", {16'd0, dut.acc_q}, 32'd0);

    // I with lifetime 3: recycle with lifetime 2 in the same cycle.
    bus.instr       = mk(2'b00, 16'd0);
    bus.input_empty = 1'b0;
    bus.input_dout  = 32'h0007_0003;
    work_q.push_back(32'h0007_0002);
    sample();
    chk("i3_input_de", {31'd0, bus.input_de}, 32'd1);
    chk("i3_work_en", {31'd0, bus.work_en}, 32'd1);
    next();

    // I against an empty input FIFO stalls for 3 cycles.
    bus.input_empty = 1'b1;
    bus.input_dout  = 32'h0005_0001;
    for (int i = 0; i < 3; i++) begin
      sample();
      chk("iempty_ready", {31'd0, bus.instr_ready}, 32'd0);
      next();
      exp_stall++;
    end
    chk("iempty_stall", {16'd0, bus.stall_cnt}, exp_stall);
    bus.input_empty = 1'b0;
    sample();
    chk("iempty_consume", {31'd0, bus.instr_ready}, 32'd1);
    next();
    chk("iempty_stall_hold", {16'd0, bus.stall_cnt}, exp_stall);

    // A with nonzero imm against a full MAC FIFO stalls without pushing.
    bus.input_empty = 1'b1;
    bus.instr       = mk(2'b10, 16'd2);
    bus.macc_full   = 1'b1;
    sample();
    chk("afull_ready", {31'd0, bus.instr_ready}, 32'd0);
    chk("afull_macc_en", {31'd0, bus.macc_en}, 32'd0);
    next();
    exp_stall++;
    chk("afull_stall", {16'd0, bus.stall_cnt}, exp_stall);
    // A 0 needs no push, so a full FIFO does not matter.
    bus.instr = mk(2'b10, 16'd0);
    sample();
    chk("a0_ready", {31'd0, bus.instr_ready}, 32'd1);
    chk("a0_macc_en", {31'd0, bus.macc_en}, 32'd0);
    next();
    bus.macc_full = 1'b0;

    // M with wrap: X=5, 5*0x7fff = 0x27ffb -> 0x7ffb.
    bus.instr = mk(2'b01, 16'h7fff);
    next();
    chk("mwrap_acc", {16'd0, dut.acc_q}, 32'h0000_7ffb);
    bus.instr = mk(2'b10, 16'd3);
    macc_q.push_back(32'h7ffb_0003);
    next();

    // F: reduce -10 and 7, emit -3.
    bus.instr = mk(2'b11, 16'd0);
    sample();
    chk("f_accept_ready", {31'd0, bus.instr_ready}, 32'd0);
    chk("f_accept_busy", {31'd0, bus.busy}, 32'd0);
    next();
    bus.macc_empty = 1'b0;
    bus.macc_dout  = 32'hfff6_0001;
    sample();
    chk("flush1_de", {31'd0, bus.macc_de}, 32'd1);
    chk("flush1_busy", {31'd0, bus.busy}, 32'd1);
    chk("flush1_ready", {31'd0, bus.instr_ready}, 32'd0);
    next();
    bus.macc_dout = 32'h0007_0002;
    sample();
    chk("flush2_de", {31'd0, bus.macc_de}, 32'd1);
    next();
    bus.macc_empty = 1'b1;
    sample();
    chk("flush_end_de", {31'd0, bus.macc_de}, 32'd0);
    chk("flush_end_ready", {31'd0, bus.instr_ready}, 32'd0);
    next();
    out_q.push_back(32'hfffd_0001);
    sample();
    chk("emit_en", {31'd0, bus.output_en}, 32'd1);
    chk("emit_ready", {31'd0, bus.instr_ready}, 32'd1);
    next();
    bus.instr_valid = 1'b0;
    sample();
    chk("post_emit_busy", {31'd0, bus.busy}, 32'd0);
    chk("post_emit_stall", {16'd0, bus.stall_cnt}, exp_stall);
    next();

    // F with output_full for 2 EMIT cycles.
    bus.instr_valid = 1'b1;
    bus.output_full = 1'b1;
    next();
    next();
    for (int i = 0; i < 2; i++) begin
      sample();
      chk("emitfull_busy", {31'd0, bus.busy}, 32'd1);
      chk("emitfull_en", {31'd0, bus.output_en}, 32'd0);
      chk("emitfull_ready", {31'd0, bus.instr_ready}, 32'd0);
      next();
      exp_stall++;
    end
    chk("emitfull_stall", {16'd0, bus.stall_cnt}, exp_stall);
    bus.output_full = 1'b0;
    out_q.push_back(32'h0000_0001);
    sample();
    chk("emitfull_push", {31'd0, bus.output_en}, 32'd1);
    next();

    // Reset in the middle of FLUSH abandons the F.
    bus.instr = mk(2'b01, 16'd3);
    next();
    chk("m3_acc", {16'd0, dut.acc_q}, 32'h0000_000f);
    bus.instr = mk(2'b11, 16'd0);
    next();
    bus.macc_empty = 1'b0;
    bus.macc_dout  = 32'h0004_0000;
    next();
    chk("mid_flush_sum", {16'd0, dut.sum_q}, 32'h0000_0004);
    reset = 1'b0;
    sample();
    chk("rstf_busy", {31'd0, bus.busy}, 32'd0);
    chk("rstf_macc_de", {31'd0, bus.macc_de}, 32'd0);
    chk("rstf_ready", {31'd0, bus.instr_ready}, 32'd0);
    chk("rstf_acc", {16'd0, dut.acc_q}, 32'd0);
    chk("rstf_sum", {16'd0, dut.sum_q}, 32'd0);
    chk("rstf_stall", {16'd0, bus.stall_cnt}, 32'd0);
    next();
    bus.macc_empty  = 1'b1;
    bus.instr_valid = 1'b0;
    reset           = 1'b1;

    // Idle RUN: no strobes.
    sample();
    chk("idle_ready", {31'd0, bus.instr_ready}, 32'd0);
    chk("idle_strobes", {28'd0, bus.input_de, bus.work_en, bus.macc_en, bus.output_en}, 32'd0);
    next();

    sample();
    chk("sb_work_left", work_q.size(), 32'd0);
    chk("sb_macc_left", macc_q.size(), 32'd0);
    chk("sb_out_left", out_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
